// File: rtl/cadr_tpclk_gen.sv
// rtl/cadr_tpclk_gen.sv - synchronous CADR machine-clock generator (optional taps: CADR_TPCLK_TAPS_EN)
module cadr_tpclk_gen #(
    parameter int TICK_NS  = 10,
    parameter int LONG_EXT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [1:0] speed,
    input  logic       ilong,
    input  logic       hang,
    output logic       tpclk,
    output logic       tpwp,
    output logic       cycle_start,
    output logic [4:0] dly
);

    localparam logic [4:0] LONG_EXT_W = 5'(LONG_EXT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_HANG,
        S_LOW
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [4:0] cnt;
    logic [4:0] cnt_nx;
    logic [1:0] speed_q;
    logic       ilong_q;
    logic       start;
    logic [4:0] n_len;
    logic [4:0] h_len;
    logic       tpclk_nx;
    logic       tpwp_nx;
    logic       cs_nx;
    logic       unused_tick;

    assign unused_tick = (TICK_NS > 0);

    // Cycle geometry always comes from the values latched at cycle start.
    assign n_len = 5'd8 + {2'b00, speed_q, 1'b0} + (ilong_q ? LONG_EXT_W : 5'd0);
    assign h_len = {1'b0, n_len[4:1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= 5'd0;
            speed_q <= 2'b00;
            ilong_q <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (start) begin
                speed_q <= speed;
                ilong_q <= ilong;
            end
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        start    = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_nx = 5'd0;
                if (run) begin
                    state_nx = S_HIGH;
                    start    = 1'b1;
                end
            end
            S_HIGH: begin
                if (cnt == h_len - 5'd1) begin
                    if (hang) begin
                        state_nx = S_HANG;
                    end else begin
                        state_nx = S_LOW;
                        cnt_nx   = h_len;
                    end
                end else begin
                    cnt_nx = cnt + 5'd1;
                end
            end
            S_HANG: begin
                if (!hang) begin
                    state_nx = S_LOW;
                    cnt_nx   = h_len;
                end
            end
            S_LOW: begin
                if (cnt == n_len - 5'd1) begin
                    cnt_nx = 5'd0;
                    if (run) begin
                        state_nx = S_HIGH;
                        start    = 1'b1;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end else begin
                    cnt_nx = cnt + 5'd1;
                end
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = 5'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they can be registered
    // and still line up with the state they describe.
    always_comb begin
        tpclk_nx = (state_nx == S_HIGH) || (state_nx == S_HANG);
        cs_nx    = start;
        tpwp_nx  = (state_nx == S_LOW) &&
                   (cnt_nx >= h_len + 5'd1) && (cnt_nx <= n_len - 5'd2);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tpclk       <= 1'b0;
            tpwp        <= 1'b0;
            cycle_start <= 1'b0;
        end else begin
            tpclk       <= tpclk_nx;
            tpwp        <= tpwp_nx;
            cycle_start <= cs_nx;
        end
    end

`ifdef CADR_TPCLK_TAPS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dly <= 5'b00000;
        end else begin
            dly <= {dly[3:0], tpclk};
        end
    end
`else
    assign dly = 5'b00000;
`endif

endmodule

// File: tb/tb_cadr_tpclk_gen.sv
// tb/tb_cadr_tpclk_gen.sv - scoreboard bench for cadr_tpclk_gen with a cycle-level reference model
module tb_cadr_tpclk_gen;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       run   = 1'b0;
    logic [1:0] speed = 2'b00;
    logic       ilong = 1'b0;
    logic       hang  = 1'b0;
    logic       tpclk;
    logic       tpwp;
    logic       cycle_start;
    logic [4:0] dly;

    cadr_tpclk_gen #(
        .TICK_NS (10),
        .LONG_EXT(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .speed      (speed),
        .ilong      (ilong),
        .hang       (hang),
        .tpclk      (tpclk),
        .tpwp       (tpwp),
        .cycle_start(cycle_start),
        .dly        (dly)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       tp;
        logic       wp;
        logic       cs;
        logic [4:0] dl;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    // Reference model: position within the cycle, cycle length, stall flag.
    bit         m_active  = 0;
    bit         m_hanging = 0;
    bit         m_tp      = 0;
    int         m_p       = 0;
    int         m_n       = 8;
    logic [4:0] m_hist    = '0;
    int         hold      = 0;
    bit         did_rst   = 0;

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, req);
        end
    endtask

    task automatic model_step();
        exp_t e;
        bit   cs;
        cs = 0;
        if (reset) begin
            m_active  = 0;
            m_hanging = 0;
            m_p       = 0;
            m_hist    = '0;
        end else begin
            m_hist = {m_hist[3:0], m_tp};
            if (!m_active) begin
                if (run) begin
                    m_active = 1;
                    m_n      = 8 + 2 * int'(speed) + (ilong ? 4 : 0);
                    m_p      = 0;
                    cs       = 1;
                end
            end else if (m_hanging) begin
                if (!hang) begin
                    m_hanging = 0;
                    m_p       = m_n / 2;
                end
            end else if (m_p == m_n / 2 - 1 && hang) begin
                m_hanging = 1;
            end else if (m_p == m_n - 1) begin
                if (run) begin
                    m_n = 8 + 2 * int'(speed) + (ilong ? 4 : 0);
                    m_p = 0;
                    cs  = 1;
                end else begin
                    m_active = 0;
                end
            end else begin
                m_p++;
            end
        end
        m_tp = m_active && (m_p < m_n / 2 || m_hanging);
        e.tp = m_tp;
        e.wp = m_active && !m_hanging && (m_p >= m_n / 2 + 1) && (m_p <= m_n - 2);
        e.cs = cs;
`ifdef CADR_TPCLK_TAPS_EN
        e.dl = m_hist;
`else
        e.dl = 5'b00000;
`endif
        sb.push_back(e);
    endtask

    task automatic tick(input logic rst, input logic r, input logic [1:0] s,
                        input logic il, input logic h);
        @(negedge clk);
        reset = rst;
        run   = r;
        speed = s;
        ilong = il;
        hang  = h;
        @(posedge clk);
        model_step();
    endtask

    task automatic reset_mid();
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_tpclk", {4'b0, tpclk}, 5'd0);
        check("async_rst_tpwp", {4'b0, tpwp}, 5'd0);
        check("async_rst_cs", {4'b0, cycle_start}, 5'd0);
        check("async_rst_dly", dly, 5'd0);
        @(posedge clk);
        model_step();
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check("tpclk", {4'b0, tpclk}, {4'b0, mon_e.tp});
            check("tpwp", {4'b0, tpwp}, {4'b0, mon_e.wp});
            check("cycle_start", {4'b0, cycle_start}, {4'b0, mon_e.cs});
            check("dly", dly, mon_e.dl);
        end
    end

    initial begin
        tick(1, 0, 2'd0, 0, 0);
        tick(1, 1, 2'd0, 0, 0);
        check("reset_tpclk", {4'b0, tpclk}, 5'd0);
        check("reset_dly", dly, 5'd0);

        // Nominal 8-tick cycles straight out of reset.
        for (int i = 0; i < 40; i++) tick(0, 1, 2'd0, 0, 0);

        // Longest cycle, then a mid-cycle speed change.
        for (int i = 0; i < 60; i++) tick(0, 1, (i < 20) ? 2'd3 : 2'd0, 1, 0);

        // Hang held 5 ticks from cnt=H-1, then stray pulses at cnt=1.
        for (int i = 0; i < 80; i++) begin
            logic h;
            if (hold == 0 && m_active && !m_hanging && m_p == m_n / 2 - 1 && i < 40) hold = 5;
            h = (hold > 0) || (i >= 40 && m_active && m_p == 1);
            if (hold > 0) hold--;
            tick(0, 1, 2'd0, 0, h);
        end

        // Run dropped early in a cycle, then reasserted.
        for (int i = 0; i < 60; i++) begin
            logic r;
            r = !(m_active && m_p >= 2 && i < 30) && !(i >= 30 && i < 34);
            tick(0, r, 2'd0, 0, 0);
        end

        for (int i = 0; i < 1500; i++) begin
            if (m_hanging && !did_rst) begin
                did_rst = 1;
                reset_mid();
            end
            tick(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 9) != 0),
                 2'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
        end

        @(negedge clk);
        check("mid_hang_reset_seen", {4'b0, did_rst}, 5'd1);
        check("scoreboard_drained", 5'(sb.size()), 5'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cadr_tpclk_gen.md
# cadr_tpclk_gen

Synchronous replacement for the CADR delay-line clock chain. Counts ticks of a fast reference clock, 10 ns per tick, and generates the machine clock (`tpclk`), the write pulse (`tpwp`) and a cycle-start strobe. The speed code and the long-instruction extension select the cycle length. `hang` stretches the high phase. A 5-tap registered delay vector reproduces the 10/20/30/40/50 ns taps that downstream timing logic expects from a TD50 delay line.

## Interface
- `TICK_NS`, 10, nominal period of `clk` in ns; documentation only, no logic depends on it.
- `LONG_EXT`, 4, ticks added to the cycle when `ilong` is latched.
- `clk`  in  1  reference clock, one tick per edge.
- `reset`  in  1  asynchronous, active-high reset.
- `run`  in  1  1 = generate cycles; 0 = stop at the end of the current cycle.
- `speed`  in  2  cycle-length code; latched at cycle start.
- `ilong`  in  1  long-instruction request; latched at cycle start.
- `hang`  in  1  stall request; holds `tpclk` high while asserted at the end of the high phase.
- `tpclk`  out  1  machine clock.
- `tpwp`  out  1  write pulse inside the low phase.
- `cycle_start`  out  1  one-tick strobe on the first tick of each cycle.
- `dly`  out  5  `dly[k]` = `tpclk` delayed by k+1 ticks.

## Operation
- Base length B by `speed`: 00→8, 01→10, 10→12, 11→14 ticks.
- Cycle length N = B + (`ilong` ? `LONG_EXT` : 0). High-phase length H = N/2. N is always even.
- `speed` and `ilong` are latched once per cycle, on the cycle's first tick. Changes during a cycle take effect at the next cycle.
- Tick counter `cnt`, 5 bits, runs 0..N−1. Maximum N = 18.
- States:
  - IDLE: `tpclk`=0, `cnt`=0.
  - HIGH: `cnt` 0..H−1, `tpclk`=1.
  - HANG: `tpclk`=1, `cnt` frozen at H−1.
  - LOW: `cnt` H..N−1, `tpclk`=0.
- Transitions:
  - IDLE→HIGH when `run`=1. This edge sets `cnt`=0, latches `speed`/`ilong`, and pulses `cycle_start`.
  - HIGH, `cnt`=H−1:
    - `hang`=1 → HANG.
    - else → LOW with `cnt`=H.
  - HANG → LOW with `cnt`=H on the first tick `hang`=0.
  - LOW, `cnt`=N−1:
    - `run`=1 → HIGH with `cnt`=0, relatch, pulse `cycle_start`.
    - `run`=0 → IDLE.
- `tpwp`=1 exactly when state=LOW and H+1 ≤ `cnt` ≤ N−2. For N=8 that is `cnt` 5 and 6 (2 ticks).
- `run` is only consulted at IDLE and at the end of a cycle. Deasserting it never truncates a cycle.
- `hang` is only consulted at `cnt`=H−1 and while in HANG. A `hang` pulse at any other point is ignored.
- `dly` is a shift register: `dly[0]` ← `tpclk`, `dly[k]` ← `dly[k−1]`. It shifts every tick, including in IDLE and HANG.

## Timing
- All outputs are registered and change only on rising `clk` or on `reset`.
- Reset (asynchronous, any time, including mid-cycle or mid-hang):
  - state=IDLE, `cnt`=0.
  - `tpclk`=`tpwp`=`cycle_start`=0, `dly`=5'b00000.
  - Latched speed=00, latched ilong=0.
- First edge after reset release with `run`=1: `tpclk`=1 and `cycle_start`=1 on that same edge. There is no extra idle tick.
- `cycle_start` is high for exactly one tick per cycle, coincident with `tpclk` rising.
- Cycle period is exactly N ticks plus the number of ticks spent in HANG.
- `tpclk` rising to `tpwp` rising: H+1 ticks. `tpwp` falls 1 tick before the next `tpclk` rising.

## Configuration
- `CADR_TPCLK_TAPS_EN`:
  - Defined: the `dly` shift register is built as described.
  - Undefined: `dly` is tied to 5'b00000, no tap flops are generated, and all other behaviour is unchanged.

## Test plan
- Reset with `run`=1, `speed`=00, `ilong`=0 → `tpclk` pattern 1111 0000 repeating; `cycle_start` every 8 ticks; `tpwp` high at `cnt` 5,6.
- `speed`=11, `ilong`=1 → N=18: 9 ticks high, 9 low; `tpwp` high at `cnt` 10..16 (7 ticks). Change `speed` to 00 mid-cycle → the current cycle stays 18 ticks, the next cycle is 12 ticks (`ilong` still 1).
- `hang`=1 held for 5 ticks starting at `cnt`=H−1 (N=8) → high phase lasts 4+5 ticks; then 4 low ticks. `hang` pulse at `cnt`=1 only → no stretch.
- `run` dropped at `cnt`=2 → cycle completes all 8 ticks, then IDLE with `tpclk`=0. `run` reasserted → `tpclk` and `cycle_start` are 1 on the next edge.
- `reset` asserted mid-HANG → all outputs 0 immediately (asynchronous); after release the first cycle uses the reset-latched values unless new inputs are present at that edge.
- With `CADR_TPCLK_TAPS_EN` defined → `dly[0]` through `dly[4]` equal `tpclk` shifted by 1..5 ticks. Without it → `dly`=0 throughout and `tpclk`/`tpwp` are identical to the defined build.
